div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Iterative 32-bit integer divider for the CPU execute stage: restoring shift-and-subtract, one quotient bit per clock.
- Serves DIV/DIVU and REM/REMU-style instructions.
- Start/Busy/Done handshake with the control unit; the pipeline stalls while Busy=1.
- Completes the arithmetic unit alongside the combinational adder.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request a division; sampled only in IDLE or DONE.
- IsSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- Dividend  input  WIDTH  numerator; sampled with Start.
- Divisor  input  WIDTH  denominator; sampled with Start.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  single-cycle pulse when results become valid.
- Quotient  output  WIDTH  result quotient; held until the next accepted Start.
- Remainder  output  WIDTH  result remainder; held until the next accepted Start.
- DivByZero  output  1  set with Done when Divisor==0; held like the results.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Busy=0, Done=0, DivByZero=0, Quotient=0, Remainder=0, counter=0.
- Reset asserted mid-operation aborts the operation immediately; no Done pulse follows.
- States:
  - IDLE: waits for Start=1.
  - RUN: one shift-subtract step per cycle.
  - FIX: sign correction of the results.
  - DONE: Done=1 for exactly one cycle, then returns to IDLE.
- Start accepted (IDLE or DONE state):
  - Latch IsSigned and the operand signs.
  - Load magnitudes: for signed operands, take the absolute value of any negative operand; unsigned operands load as-is.
  - Clear the partial remainder; counter=WIDTH-1; go to RUN.
- Start while Busy=1 is ignored; operands are not re-sampled.
- RUN step:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit difference.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter; after the step with counter==0, go to FIX.
- FIX:
  - If signed and the operand signs differ, negate the quotient.
  - If signed and the dividend was negative, negate the remainder.
  - The remainder sign always follows the dividend.
- Latency: Start sampled at edge N; Done high in cycle N+WIDTH+2; Busy high for cycles N+1 through N+WIDTH+1.
- Divide by zero (Divisor==0 at Start):
  - Skip RUN and go directly to FIX.
  - Quotient = all ones; Remainder = original Dividend; DivByZero=1.
  - Done arrives in cycle N+2.
- Signed overflow (-2^(WIDTH-1) / -1): Quotient=0x80000000, Remainder=0, DivByZero=0. This falls out of the magnitude path with no special case.
- Back-to-back: Start in the DONE cycle is accepted, so the next operation begins without an IDLE gap.
- DivByZero clears on the next accepted Start.

Optional Feature:
- Macro: DIV32_EARLY_OUT_EN.
- Defined: when an operation is accepted and the divisor magnitude is greater than the dividend magnitude (divisor non-zero), skip RUN. FIX then yields Quotient=0 and Remainder=Dividend, with Done in cycle N+2.
- Undefined: every non-zero-divisor operation takes the full WIDTH+2 cycles; the comparator is not synthesized.

Decomposition:
- Package div_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - DIV_WIDTH=32.
  - Divide-by-zero quotient constant DIV0_QUOT = all ones.
- Sub-module div_step: combinational single iteration. Inputs are partial remainder, next dividend bit and divisor magnitude. Outputs are the next remainder and the quotient bit. It contains the WIDTH+1-bit subtractor.

Test Plan:
- Unsigned 100 / 7, IsSigned=0 -> Done in cycle N+34; Quotient=14, Remainder=2; Busy high for 33 cycles.
- Signed -100 / 7 -> Quotient=0xFFFFFFF2 (-14), Remainder=0xFFFFFFFE (-2); signed 100 / -7 -> Quotient=-14, Remainder=2.
- Divisor=0, Dividend=0x12345678 -> Done in cycle N+2; Quotient=0xFFFFFFFF, Remainder=0x12345678, DivByZero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> Quotient=0x80000000, Remainder=0; unsigned 0xFFFFFFFF / 1 -> Quotient=0xFFFFFFFF, Remainder=0.
- Start pulsed mid-RUN with new operands -> ignored, first result unchanged. Start in the DONE cycle -> second operation accepted, Done 34 cycles later.
- rst_n dropped at RUN iteration 10 -> Busy=0 and all outputs 0 asynchronously; no Done. With DIV32_EARLY_OUT_EN defined, 5 / 9 -> Quotient=0, Remainder=5, Done in cycle N+2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM encoding,
// default width, divide-by-zero quotient and the latched-operation record.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // FSM encoding (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Quotient reported for a zero divisor
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

  // Operation attributes captured when a Start is accepted
  typedef struct packed {
    logic sgn;      // two's-complement operation
    logic dvd_neg;  // dividend was negative (signed only)
    logic dvs_neg;  // divisor was negative (signed only)
    logic dz;       // divisor was zero
  } div_op_t;

  // Quotient needs negation when a signed op has operands of opposite sign
  function automatic logic quo_negate(input div_op_t op);
    return op.sgn & (op.dvd_neg ^ op.dvs_neg) & ~op.dz;
  endfunction

  // Remainder takes the sign of the dividend
  function automatic logic rem_negate(input div_op_t op);
    return op.sgn & op.dvd_neg;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration. The partial remainder is shifted
// left taking in the next dividend bit, then the divisor is trial-subtracted
// in WIDTH+1 bits. Because the incoming remainder is always below the
// divisor, the difference fits in WIDTH+1 signed bits and its MSB is the
// borrow: clear means keep the difference and emit a 1 quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, din};
  assign diff    = shifted - {1'b0, dvs};

  // Borrow clear -> subtraction succeeded
  assign qbit    = ~diff[WIDTH];

  // On restore, shifted[WIDTH] is known zero (shifted < divisor)
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider for the execute stage, one quotient bit per
// clock. Operands are converted to magnitudes on Start, divided unsigned in
// RUN, and sign-corrected in FIX; DONE pulses for one cycle.
// Optional build macro DIV32_EARLY_OUT_EN: when the divisor magnitude
// exceeds the dividend magnitude the RUN phase is skipped entirely.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  div_op_t          op;

  // Working registers: quo_r starts as the dividend magnitude and shifts
  // left each step, so its MSB is always the next dividend bit while the
  // quotient bits fill in from the LSB.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;

  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             dz_out;

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             div_zero;
  logic             skip_run;

  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;

  // Start is only honoured when the unit is not busy
  assign accept   = Start & ((state == ST_IDLE) | (state == ST_DONE));

  // Operand signs and magnitudes; -2^(WIDTH-1) maps onto itself, which is
  // the correct unsigned magnitude
  assign dvd_neg  = IsSigned & Dividend[WIDTH-1];
  assign dvs_neg  = IsSigned & Divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -Dividend : Dividend;
  assign dvs_mag  = dvs_neg ? -Divisor  : Divisor;
  assign div_zero = (Divisor == '0);

`ifdef DIV32_EARLY_OUT_EN
  // Quotient is trivially zero when the divisor is larger
  assign skip_run = div_zero | (dvs_mag > dvd_mag);
`else
  assign skip_run = div_zero;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .din     (quo_r[WIDTH-1]),
    .dvs     (dvs_r),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Control FSM, iteration counter and latched operation attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op.sgn     <= IsSigned;
            op.dvd_neg <= dvd_neg;
            op.dvs_neg <= dvs_neg;
            op.dz      <= div_zero;
            cnt        <= CNT_W'(WIDTH - 1);
            state      <= skip_run ? ST_FIX : ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX:  state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift-subtract datapath. A skipped RUN leaves the dividend magnitude in
  // the remainder so the normal sign fix reproduces the original dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (accept) begin
      dvs_r <= dvs_mag;
      if (skip_run) begin
        rem_r <= dvd_mag;
        quo_r <= div_zero ? WIDTH'(DIV0_QUOT) : '0;
      end else begin
        rem_r <= '0;
        quo_r <= dvd_mag;
      end
    end else if (state == ST_RUN) begin
      rem_r <= rem_nxt;
      quo_r <= {quo_r[WIDTH-2:0], qbit};
    end
  end

  // Result registers: sign-corrected in FIX, held through DONE and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out  <= '0;
      r_out  <= '0;
      dz_out <= 1'b0;
    end else if (accept) begin
      dz_out <= 1'b0;
    end else if (state == ST_FIX) begin
      q_out  <= quo_negate(op) ? -quo_r : quo_r;
      r_out  <= rem_negate(op) ? -rem_r : rem_r;
      dz_out <= op.dz;
    end
  end

  assign Busy      = (state == ST_RUN) | (state == ST_FIX);
  assign Done      = (state == ST_DONE);
  assign Quotient  = q_out;
  assign Remainder = r_out;
  assign DivByZero = dz_out;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed vector table, randomized operations against
// an arithmetic reference, and hand-written handshake/reset sequences.
module tb_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        IsSigned;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DIV32_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .IsSigned  (IsSigned),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer division in 64 bits (no overflow), with the
  // zero-divisor and early-out rules applied on top.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int lat);
    longint sa, sb, ma, mb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
      lat = (EARLY && mb > ma) ? 2 : 34;
    end
  endtask

  // Present an operation at the current negedge, then count cycles to Done
  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s,
                    output logic [31:0] q, output logic [31:0] r, output logic dz,
                    output int lat, output int busyc);
    Start = 1'b1; Dividend = a; Divisor = b; IsSigned = s;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 0; busyc = 0; q = '0; r = '0; dz = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (Busy) busyc++;
      if (Done) begin
        lat = j; q = Quotient; r = Remainder; dz = DivByZero;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output int lat, output int busyc);
    @(negedge clk);
    go(a, b, s, q, r, dz, lat, busyc);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    logic [31:0] gq, gr, eq, er;
    logic        gdz, edz;
    int          glat, gbusy, elat;

    tbl[0] = '{"u100/7",   32'd100,        32'd7,          1'b0, 32'd14,        32'd2,        1'b0, 34};
    tbl[1] = '{"s-100/7",  32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34};
    tbl[2] = '{"s100/-7",  32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2, 32'd2,        1'b0, 34};
    tbl[3] = '{"div0",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2};
    tbl[4] = '{"sovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,        1'b0, 34};
    tbl[5] = '{"uff/1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,        1'b0, 34};
    tbl[6] = '{"u5/9",     32'd5,          32'd9,          1'b0, 32'd0,         32'd5,        1'b0, EARLY ? 2 : 34};

    Start = 1'b0; IsSigned = 1'b0; Dividend = '0; Divisor = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_q",    Quotient,  32'd0);
    chk("rst_r",    Remainder, 32'd0);
    chk("rst_dz",   32'(DivByZero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, gq, gr, gdz, glat, gbusy);
      chk({tbl[i].nm, "_q"},    gq, tbl[i].q);
      chk({tbl[i].nm, "_r"},    gr, tbl[i].r);
      chk({tbl[i].nm, "_dz"},   32'(gdz), 32'(tbl[i].dz));
      chk({tbl[i].nm, "_lat"},  32'(glat), 32'(tbl[i].lat));
      chk({tbl[i].nm, "_busy"}, 32'(gbusy), 32'(tbl[i].lat - 1));
      @(negedge clk);
      chk({tbl[i].nm, "_pulse"}, 32'(Done), 32'd0);
      chk({tbl[i].nm, "_hold"},  Quotient, tbl[i].q);
    end

    // Randomized operations against the reference
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      logic        s;
      int          sel;
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = 32'($urandom_range(1, 20));
      else if (sel == 4) b = 32'hFFFF_FFFF;
      else               b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er, edz, elat);
      do_op(a, b, s, gq, gr, gdz, glat, gbusy);
      chk("rnd_q",   gq, eq);
      chk("rnd_r",   gr, er);
      chk("rnd_dz",  32'(gdz), 32'(edz));
      chk("rnd_lat", 32'(glat), 32'(elat));
    end

    // Start mid-RUN must be ignored
    @(negedge clk);
    Start = 1'b1; Dividend = 32'd1000; Divisor = 32'd3; IsSigned = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0;
    glat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 5) begin
        Start = 1'b1; Dividend = 32'd77; Divisor = 32'd5; IsSigned = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        glat = j; gq = Quotient; gr = Remainder;
        break;
      end
    end
    Start = 1'b0;
    chk("ign_lat", 32'(glat), 32'd34);
    chk("ign_q",   gq, 32'd333);
    chk("ign_r",   gr, 32'd1);

    // Back-to-back: second Start presented in the DONE cycle
    do_op(32'd100, 32'd7, 1'b0, gq, gr, gdz, glat, gbusy);
    chk("b2b1_q", gq, 32'd14);
    go(32'd200, 32'd9, 1'b0, gq, gr, gdz, glat, gbusy);
    chk("b2b2_lat", 32'(glat), 32'd34);
    chk("b2b2_q",   gq, 32'd22);
    chk("b2b2_r",   gr, 32'd2);

    // Reset during RUN: outputs clear immediately, no Done follows
    @(negedge clk);
    Start = 1'b1; Dividend = 32'd1000; Divisor = 32'd3; IsSigned = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", 32'(Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(Busy), 32'd0);
    chk("mid_done", 32'(Done), 32'd0);
    chk("mid_q",    Quotient,  32'd0);
    chk("mid_r",    Remainder, 32'd0);
    chk("mid_dz",   32'(DivByZero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gdz = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (Done || Busy) gdz = 1'b1;
    end
    chk("mid_nodone", 32'(gdz), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
